// File: rtl/twiddle_pkg.sv
// Shared constants and FSM encoding for the twiddle table loader.
// The CHECK state only exists when TWIDDLE_LOADER_CHECKSUM_EN is defined.
package twiddle_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 24;

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;
`endif

endpackage

// File: rtl/twiddle_loader_if.sv
// Valid/ready load stream carrying one complex coefficient per beat.
interface twiddle_loader_if
    import twiddle_pkg::*;
#(
    parameter int data_w = DATA_W_DEF
);
    logic              s_valid;
    logic              s_ready;
    logic [data_w-1:0] s_real;
    logic [data_w-1:0] s_imag;

    modport master (
        output s_valid,
        output s_real,
        output s_imag,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_real,
        input  s_imag,
        output s_ready
    );
endinterface

// File: rtl/twiddle_ram.sv
// Simple dual-port coefficient store: one write port, one registered read port.
// A read colliding with a write to the same entry returns the old contents.
module twiddle_ram
    import twiddle_pkg::*;
#(
    parameter int addr_w = ADDR_W_DEF,
    parameter int width  = 2 * DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [addr_w-1:0] wr_addr_i,
    input  logic [width-1:0]  wr_data_i,
    input  logic [addr_w-1:0] rd_addr_i,
    output logic [width-1:0]  rd_data_o
);
    localparam int DEPTH = 1 << addr_w;

    logic [width-1:0] mem_q [DEPTH];
    logic [width-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto block RAM; only the
    // readout register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // NOTE: non-blocking assignment samples mem_q before this edge's write,
    // which is what gives read-old-data on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/twiddle_loader.sv
// Loads a 2**addr_w-entry complex twiddle table from a valid/ready stream.
// Define TWIDDLE_LOADER_CHECKSUM_EN to require a trailing XOR checksum beat.
module twiddle_loader
    import twiddle_pkg::*;
#(
    parameter int addr_w = ADDR_W_DEF,
    parameter int data_w = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    twiddle_loader_if.slave   stream,
    input  logic [addr_w-1:0] rd_addr,
    output logic [data_w-1:0] rd_real,
    output logic [data_w-1:0] rd_imag,
    output logic              busy,
    output logic              table_valid,
    output logic [addr_w:0]   load_count,
    output logic              err
);
    state_e              state_q;
    state_e              state_d;
    logic [addr_w:0]     count_q;
    logic [addr_w:0]     count_d;
    logic                ready;
    logic                beat;
    logic                last_entry;
    logic                we;
    logic [2*data_w-1:0] rd_data;

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    logic              err_q;
    logic              err_d;
    logic [data_w-1:0] csum_q;
    logic [data_w-1:0] csum_d;
`endif

    assign beat       = stream.s_valid && ready;
    assign last_entry = (count_q[addr_w-1:0] == '1);
    assign we         = (state_q == LOAD) && beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
            err_q   <= err_d;
            csum_q  <= csum_d;
`endif
        end
    end

    // NOTE: every target gets a hold value before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
        err_d   = err_q;
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
                    csum_d  = '0;
`endif
                end
            end
            LOAD: begin
                if (beat) begin
                    count_d = count_q + 1'b1;
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ stream.s_real ^ stream.s_imag;
                    if (last_entry) state_d = CHECK;
`else
                    if (last_entry) state_d = DONE;
`endif
                end
            end
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
            CHECK: begin
                if (beat) begin
                    if (stream.s_real == csum_q) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b0;
        busy        = 1'b0;
        table_valid = 1'b0;
        case (state_q)
            LOAD: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
            CHECK: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
`endif
            DONE:    table_valid = 1'b1;
            default: ;
        endcase
    end

    assign stream.s_ready = ready;
    assign load_count     = count_q;

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    twiddle_ram #(
        .addr_w (addr_w),
        .width  (2 * data_w)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we),
        .wr_addr_i (count_q[addr_w-1:0]),
        .wr_data_i ({stream.s_real, stream.s_imag}),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign rd_real = rd_data[2*data_w-1:data_w];
    assign rd_imag = rd_data[data_w-1:0];

endmodule

// File: tb/tb_twiddle_loader.sv
// Scoreboard bench for twiddle_loader; reads are queued by stimulus and checked by a monitor.
// Exercises the checksum beat as well when TWIDDLE_LOADER_CHECKSUM_EN is defined.
module tb_twiddle_loader;
    import twiddle_pkg::*;

    localparam int AW          = 7;
    localparam int DW          = 24;
    localparam int DEPTH       = 1 << AW;
    localparam int BEAT_BUDGET = 50;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_real;
    logic [DW-1:0] rd_imag;
    logic          busy;
    logic          table_valid;
    logic [AW:0]   load_count;
    logic          err;

    int            checks   = 0;
    int            failures = 0;
    int            exp_count;
    logic [DW-1:0] xor_model;

    rd_exp_t       rd_q [$];
    rd_exp_t       rd_head;
    logic          rd_req     = 1'b0;
    logic          rd_pending = 1'b0;

    twiddle_loader_if #(.data_w(DW)) stream ();

    twiddle_loader #(
        .addr_w (AW),
        .data_w (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stream      (stream),
        .rd_addr     (rd_addr),
        .rd_real     (rd_real),
        .rd_imag     (rd_imag),
        .busy        (busy),
        .table_valid (table_valid),
        .load_count  (load_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read monitor: a request issued before edge N is compared after edge N.
    always @(posedge clk) rd_pending <= rd_req;

    always @(negedge clk) begin
        if (rd_pending) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 64'd1, 64'd0);
            end else begin
                rd_head = rd_q.pop_front();
                check($sformatf("rd_real[%0d]", rd_head.addr), 64'(rd_real), 64'(rd_head.re));
                check($sformatf("rd_imag[%0d]", rd_head.addr), 64'(rd_imag), 64'(rd_head.im));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_read(input logic [AW-1:0] addr, input logic [DW-1:0] re,
                               input logic [DW-1:0] im);
        rd_exp_t e;
        e.addr = addr;
        e.re   = re;
        e.im   = im;
        rd_addr = addr;
        rd_q.push_back(e);
        rd_req = 1'b1;
    endtask

    task automatic issue_read(input logic [AW-1:0] addr, input logic [DW-1:0] re,
                              input logic [DW-1:0] im);
        expect_read(addr, re, im);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] re, input logic [DW-1:0] im, input bit gap);
        int waited;
        waited = 0;
        stream.s_valid = 1'b1;
        stream.s_real  = re;
        stream.s_imag  = im;
        while (stream.s_ready !== 1'b1 && waited < BEAT_BUDGET) begin
            tick();
            waited++;
        end
        if (stream.s_ready !== 1'b1) begin
            check("beat_accept_timeout", 64'(waited), 64'd0);
            stream.s_valid = 1'b0;
            return;
        end
        tick();
        exp_count++;
        xor_model = xor_model ^ re ^ im;
        check("load_count", 64'(load_count), 64'(exp_count));
        if (gap) begin
            stream.s_valid = 1'b0;
            tick();
            check("load_count_gap", 64'(load_count), 64'(exp_count));
            if (exp_count < DEPTH) check("busy_gap", 64'(busy), 64'd1);
        end
    endtask

    task automatic begin_load();
        exp_count = 0;
        xor_model = '0;
        pulse_start();
        check("busy_after_start", 64'(busy), 64'd1);
        check("count_after_start", 64'(load_count), 64'd0);
        check("valid_after_start", 64'(table_valid), 64'd0);
    endtask

    task automatic finish_load();
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
        check("busy_in_check", 64'(busy), 64'd1);
        send_checksum(xor_model);
`else
        stream.s_valid = 1'b0;
`endif
        check("table_valid_done", 64'(table_valid), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("count_done", 64'(load_count), 64'(DEPTH));
        check("err_done", 64'(err), 64'd0);
    endtask

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    task automatic send_checksum(input logic [DW-1:0] value);
        int waited;
        waited = 0;
        stream.s_valid = 1'b1;
        stream.s_real  = value;
        stream.s_imag  = '0;
        while (stream.s_ready !== 1'b1 && waited < BEAT_BUDGET) begin
            tick();
            waited++;
        end
        if (stream.s_ready !== 1'b1) check("csum_accept_timeout", 64'(waited), 64'd0);
        else tick();
        stream.s_valid = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        rst            = 1'b1;
        start          = 1'b0;
        rd_addr        = '0;
        stream.s_valid = 1'b0;
        stream.s_real  = '0;
        stream.s_imag  = '0;
        exp_count      = 0;
        xor_model      = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_table_valid", 64'(table_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_load_count", 64'(load_count), 64'd0);
        check("rst_rd_real", 64'(rd_real), 64'd0);
        check("rst_rd_imag", 64'(rd_imag), 64'd0);
        check("rst_s_ready", 64'(stream.s_ready), 64'd0);
        rst = 1'b0;
        tick();

        // Full back-to-back load: real=i, imag=~i.
        begin_load();
        for (int i = 0; i < DEPTH; i++) begin
            v = DW'(i);
            send_beat(v, ~v, 1'b0);
        end
        finish_load();
        issue_read(7'd5,   24'h000005, 24'hFFFFFA);
        issue_read(7'd0,   24'h000000, 24'hFFFFFF);
        issue_read(7'd127, 24'h00007F, 24'hFFFF80);

        // Stalled stream: valid toggles 1/0.
        begin_load();
        for (int i = 0; i < DEPTH; i++) begin
            v = DW'(i);
            send_beat(v + 24'h000100, v ^ 24'h0ABCDE, 1'b1);
        end
        finish_load();
        issue_read(7'd0,   24'h000100, 24'h0ABCDE);
        issue_read(7'd77,  24'h00014D, 24'h0ABC93);
        issue_read(7'd127, 24'h00017F, 24'h0ABCA1);

        // Partial load aborted by reset; start in the same cycle must lose.
        begin_load();
        for (int i = 0; i < 40; i++) begin
            v = DW'(i);
            send_beat(24'h200000 | v, 24'h300000 | v, 1'b0);
        end
        rst            = 1'b1;
        start          = 1'b1;
        stream.s_valid = 1'b0;
        tick();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_table_valid", 64'(table_valid), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        check("midrst_load_count", 64'(load_count), 64'd0);
        check("midrst_rd_real", 64'(rd_real), 64'd0);
        check("midrst_rd_imag", 64'(rd_imag), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("midrst_still_idle", 64'(busy), 64'd0);

        // Reload with read-during-write at entry 10 and a stray start at beat 60.
        begin_load();
        for (int i = 0; i < DEPTH; i++) begin
            v = DW'(i);
            if (i == 10) expect_read(7'd10, 24'h20000A, 24'h30000A);
            if (i == 11) expect_read(7'd10, 24'h40000A, 24'h50000A);
            if (i == 60) start = 1'b1;
            send_beat(24'h400000 | v, 24'h500000 | v, 1'b0);
            rd_req = 1'b0;
            start  = 1'b0;
        end
        finish_load();
        issue_read(7'd10,  24'h40000A, 24'h50000A);
        issue_read(7'd39,  24'h400027, 24'h500027);
        issue_read(7'd100, 24'h400064, 24'h500064);

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
        // Corrupted checksum: bit 0 flipped.
        begin_load();
        for (int i = 0; i < DEPTH; i++) begin
            v = DW'(i);
            send_beat(v, ~v, 1'b0);
        end
        send_checksum(xor_model ^ 24'h000001);
        check("bad_csum_err", 64'(err), 64'd1);
        check("bad_csum_table_valid", 64'(table_valid), 64'd0);
        check("bad_csum_busy", 64'(busy), 64'd0);
        check("bad_csum_idle_ready", 64'(stream.s_ready), 64'd0);
        tick();
        check("bad_csum_err_sticky", 64'(err), 64'd1);
        pulse_start();
        check("start_clears_err", 64'(err), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        tick();
        tick();
        check("rd_queue_empty", 64'(rd_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/twiddle_loader.md
TWIDDLE_LOADER -- requirements
Module: twiddle_loader

Interface
REQ-001 The block SHALL have parameter addr_w, default 7, meaning table address width (depth 2**addr_w entries).
REQ-002 The block SHALL have parameter data_w, default 24, meaning width of each real and imaginary word.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, meaning a one-cycle request to begin a table load.
REQ-006 The block SHALL have port s_valid, input, 1, meaning the load-stream word is valid.
REQ-007 The block SHALL have port s_ready, output, 1, meaning the block accepts a load-stream word this cycle.
REQ-008 The block SHALL have port s_real, input, data_w, meaning the real coefficient word of the current beat.
REQ-009 The block SHALL have port s_imag, input, data_w, meaning the imaginary coefficient word of the current beat.
REQ-010 The block SHALL have port rd_addr, input, addr_w, meaning the table read address.
REQ-011 The block SHALL have port rd_real, output, data_w, meaning registered real readout.
REQ-012 The block SHALL have port rd_imag, output, data_w, meaning registered imaginary readout.
REQ-013 The block SHALL have port busy, output, 1, meaning a load is in progress.
REQ-014 The block SHALL have port table_valid, output, 1, meaning a complete table is loaded.
REQ-015 The block SHALL have port load_count, output, addr_w+1, meaning the number of entries written in the current load.
REQ-016 The block SHALL have port err, output, 1, meaning the checksum failed (sticky until the next start or rst).

Function
REQ-017 FSM states SHALL be IDLE, LOAD, CHECK (macro only) and DONE.
REQ-018 start in IDLE or DONE SHALL move the FSM to LOAD next cycle, clear load_count, table_valid and err, and set busy.
REQ-019 start in LOAD or CHECK SHALL be ignored.
REQ-020 s_ready SHALL be 1 only in LOAD or CHECK; a beat transfers when s_valid and s_ready are both 1.
REQ-021 Each LOAD transfer SHALL write {s_real, s_imag} to entry load_count[addr_w-1:0] and increment load_count.
REQ-022 Entries SHALL be written strictly in ascending order 0..2**addr_w-1, with no wrap.
REQ-023 The transfer writing entry 2**addr_w-1 SHALL move the FSM to CHECK if the macro is defined, else to DONE.
REQ-024 In DONE: busy=0 and table_valid=1; load_count holds 2**addr_w.
REQ-025 Read port: rd_real/rd_imag SHALL equal the entry at rd_addr sampled one clk earlier, in every state.
REQ-026 A read and write to the same address in the same cycle SHALL return the old data.
REQ-027 Gaps in s_valid SHALL stall the load indefinitely with no timeout.

Reset
REQ-028 rst SHALL force IDLE, busy=0, table_valid=0, err=0, load_count=0, rd_real=0 and rd_imag=0 on the next edge, including mid-load.
REQ-029 Table contents SHALL NOT be reset; rst has priority over start.

Configuration
REQ-030 With TWIDDLE_LOADER_CHECKSUM_EN defined: a running XOR of all s_real and s_imag words is kept; in CHECK, one extra beat is accepted and its s_real[data_w-1:0] is compared against the running XOR. On match the FSM goes to DONE; on mismatch it sets err=1, keeps table_valid=0 and goes to IDLE.
REQ-031 Without TWIDDLE_LOADER_CHECKSUM_EN: CHECK and the accumulator are absent, and err is tied to 0.

Structure
REQ-032 A shared package twiddle_pkg SHALL hold the FSM state encoding and the default addr_w/data_w constants.
REQ-033 The storage SHALL be one sub-module, twiddle_ram: simple dual-port, one write port and one registered read port, 2**addr_w x 2*data_w.

Verification
REQ-034 Full load: start, then 128 back-to-back beats with real=i and imag=~i -> table_valid=1 after the last beat; rd_addr=5 gives rd_real=5 and rd_imag=~5 one cycle later.
REQ-035 Stalled stream: s_valid toggled 1/0 -> exactly 128 writes, load_count steps by 1 per transfer, and busy=1 throughout.
REQ-036 Mid-load rst after 40 beats -> all outputs reach their reset values next cycle; a new start followed by 128 beats completes normally.
REQ-037 start asserted at beat 60 -> ignored; load_count continues 61, 62, ...
REQ-038 Read-during-write at address 10 -> rd_real shows the previous content, and the new value on the next read.
REQ-039 With the macro: correct checksum -> table_valid=1 and err=0; a corrupted checksum (bit 0 flipped) -> err=1, table_valid=0 and FSM in IDLE.
